// File: rtl/fhe_op_issue_queue_pkg.sv
// fhe_op_issue_queue_pkg: shared FHE op types and issue FSM states
package fhe_op_issue_queue_pkg;
  localparam int REG_IDX_W = 5;
  typedef enum logic [2:0] {NO_OP, OP_CT_CT_ADD, OP_CT_PT_ADD, OP_CT_PT_MUL, OP_CT_CT_MUL} mode_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef struct packed {
    mode_t    mode;
    reg_idx_t idx1_a;
    reg_idx_t idx1_b;
    reg_idx_t idx2_a;
    reg_idx_t idx2_b;
    reg_idx_t out_a;
    reg_idx_t out_b;
  } operation;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} issue_state_t;
endpackage

// File: rtl/fhe_op_issue_queue_op_fifo.sv
// op_fifo: power-of-two FIFO with wrap-bit pointers and synchronous flush
module op_fifo
  import fhe_op_issue_queue_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = operation
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  T                       din,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign count = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/fhe_op_issue_queue.sv
// fhe_op_issue_queue: buffers FHE ops and issues them one at a time to the cpu with timeout
module fhe_op_issue_queue
  import fhe_op_issue_queue_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 500,
  parameter int CNT_W          = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  operation               in_op,
  output logic                   in_ready,
  input  logic                   flush,
  output operation               cpu_op,
  input  logic                   cpu_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_W-1:0]       retired_cnt,
  output logic                   timeout_err,
  input  logic                   err_clear
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  issue_state_t state;
  logic [TW-1:0] tmr;
  operation head;
  logic full, empty, expire, retire, pop;
  assign in_ready = !full && !flush;
  assign expire   = state == WAIT && tmr == TW'(TIMEOUT_CYCLES - 1);
  assign retire   = state == WAIT && (cpu_done || expire);
  // a flushed queue has nothing to hand over, so flush also blocks the pop
  assign pop      = !empty && !flush && (state == IDLE || retire);
  assign busy     = state != IDLE || !empty;
  op_fifo #(.DEPTH(DEPTH), .T(operation)) u_fifo (
    .clk   (clk),
    .reset_n(reset_n),
    .push  (in_valid && in_ready && in_op.mode != NO_OP),
    .pop   (pop),
    .flush (flush),
    .din   (in_op),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      cpu_op      <= '0;
      tmr         <= '0;
      retired_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (err_clear) timeout_err <= 1'b0;
      if (expire && !cpu_done) timeout_err <= 1'b1;
      if (retire) retired_cnt <= retired_cnt + 1'b1;
      case (state)
        IDLE: if (pop) begin
          cpu_op <= head;
          state  <= ISSUE;
        end
        ISSUE: begin
          cpu_op.mode <= NO_OP;
          tmr         <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          tmr <= tmr + 1'b1;
          if (pop) begin
            cpu_op <= head;
            state  <= ISSUE;
          end else if (retire) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fhe_op_issue_queue.sv
// tb_fhe_op_issue_queue: random + directed stimulus checked against a queue-based reference model
module tb_fhe_op_issue_queue;
  import fhe_op_issue_queue_pkg::*;
  localparam int DEPTH = 8, TO = 10, CNT_W = 16;
  logic clk = 0, reset_n = 0, in_valid = 0, flush = 0, cpu_done = 0, err_clear = 0;
  operation in_op = '0;
  logic in_ready, busy, timeout_err;
  operation cpu_op;
  logic [$clog2(DEPTH):0] count;
  logic [CNT_W-1:0] retired_cnt;
  fhe_op_issue_queue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_op(in_op), .in_ready(in_ready),
    .flush(flush), .cpu_op(cpu_op), .cpu_done(cpu_done), .busy(busy), .count(count),
    .retired_cnt(retired_cnt), .timeout_err(timeout_err), .err_clear(err_clear)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // reference model: queued ops, whether an op is in flight, cycles it has waited
  operation mq[$];
  operation mop;
  bit inflight, fresh, merr;
  int waited, mret;
  bit prev_live;
  task automatic model_reset();
    mq.delete();
    mop = '0;
    inflight = 0;
    fresh = 0;
    merr = 0;
    waited = 0;
    mret = 0;
    prev_live = 0;
  endtask
  task automatic model_step(input bit v, input operation op, input bit fl, dn, ec);
    bit rdy, done_now, hung, take;
    rdy = mq.size() < DEPTH && !fl;
    done_now = 0;
    hung = 0;
    if (inflight && !fresh) begin
      waited++;
      done_now = dn || waited == TO;
      hung = !dn && waited == TO;
    end
    if (ec) merr = 0;
    if (hung) merr = 1;
    if (done_now) begin
      mret++;
      inflight = 0;
    end
    if (fresh) begin
      fresh = 0;
      mop.mode = NO_OP;
      waited = 0;
    end
    take = !inflight && mq.size() > 0 && !fl;
    if (take) begin
      mop = mq.pop_front();
      inflight = 1;
      fresh = 1;
    end
    if (fl) mq.delete();
    else if (v && rdy && op.mode != NO_OP) mq.push_back(op);
  endtask
  task automatic check_outputs();
    bit live;
    check("cpu_op", 64'(cpu_op), 64'(mop));
    check("count", 64'(count), 64'(mq.size()));
    check("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH && !flush));
    check("busy", 64'(busy), 64'(inflight || mq.size() > 0));
    check("retired_cnt", 64'(retired_cnt), 64'(mret % 65536));
    check("timeout_err", 64'(timeout_err), 64'(merr));
    live = cpu_op.mode != NO_OP;
    check("no_back2back", 64'(prev_live && live), 64'(0));
    prev_live = live;
  endtask
  task automatic cycle(input bit v, input operation op, input bit fl, dn, ec);
    in_valid = v;
    in_op = op;
    flush = fl;
    cpu_done = dn;
    err_clear = ec;
    model_step(v, op, fl, dn, ec);
    @(posedge clk);
    #1;
    check_outputs();
  endtask
  function automatic operation rand_op(input bit allow_noop);
    operation o;
    o.mode   = mode_t'(allow_noop ? $urandom_range(0, 4) : $urandom_range(1, 4));
    o.idx1_a = reg_idx_t'($urandom_range(0, 31));
    o.idx1_b = reg_idx_t'($urandom_range(0, 31));
    o.idx2_a = reg_idx_t'($urandom_range(0, 31));
    o.idx2_b = reg_idx_t'($urandom_range(0, 31));
    o.out_a  = reg_idx_t'($urandom_range(0, 31));
    o.out_b  = reg_idx_t'($urandom_range(0, 31));
    return o;
  endfunction
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, 0);
  endtask
  task automatic do_reset();
    reset_n = 0;
    #1;
    model_reset();
    check("rst_cpu_op", 64'(cpu_op), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_retired", 64'(retired_cnt), 64'(0));
    check("rst_terr", 64'(timeout_err), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    reset_n = 1;
  endtask
  initial begin
    operation op;
    int guard;
    #3;
    do_reset();
    // single ADD {0,1,2,3 -> 5,6}, done 3 cycles after issue
    op = '{OP_CT_CT_ADD, 5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd6};
    cycle(1, op, 0, 0, 0);
    cycle(0, '0, 0, 0, 0);
    check("issued_add", 64'(cpu_op), 64'(op));
    idle(2);
    cycle(0, '0, 0, 1, 0);
    idle(1);
    check("one_retired", 64'(retired_cnt), 64'(1));
    check("busy_drop", 64'(busy), 64'(0));
    // fill past capacity while the cpu stalls, then retire everything
    for (int i = 0; i < 10; i++) cycle(1, rand_op(0), 0, 0, 0);
    check("full_not_ready", 64'(in_ready), 64'(0));
    for (int i = 0; i < 12; i++) begin
      cycle(0, '0, 0, 1, 0);
      idle(1);
    end
    // timeout path, then clear the flag
    cycle(1, rand_op(0), 0, 0, 0);
    cycle(1, rand_op(0), 0, 0, 0);
    idle(TO + 2);
    check("terr_set", 64'(timeout_err), 64'(1));
    cycle(0, '0, 0, 0, 1);
    check("terr_clr", 64'(timeout_err), 64'(0));
    cycle(0, '0, 0, 1, 0);
    idle(2);
    // flush during WAIT with 4 queued
    for (int i = 0; i < 4; i++) cycle(1, rand_op(0), 0, 0, 0);
    cycle(0, '0, 1, 0, 0);
    check("flush_count", 64'(count), 64'(0));
    cycle(0, '0, 0, 1, 0);
    idle(3);
    // done during ISSUE is stale
    do_reset();
    cycle(1, rand_op(0), 0, 0, 0);
    cycle(0, '0, 0, 0, 0);
    cycle(0, '0, 0, 1, 0);
    idle(1);
    cycle(0, '0, 0, 1, 0);
    check("stale_done", 64'(retired_cnt), 64'(1));
    // NO_OP is not queued; async reset mid-WAIT
    op = rand_op(0);
    op.mode = NO_OP;
    cycle(1, op, 0, 0, 0);
    check("noop_drop", 64'(count), 64'(0));
    cycle(1, rand_op(0), 0, 0, 0);
    cycle(1, rand_op(0), 0, 0, 0);
    idle(2);
    do_reset();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int dp = (i / 500) % 2 == 0 ? 6 : 2;
      cycle($urandom_range(0, 1), rand_op(1), $urandom_range(0, 39) == 0,
            $urandom_range(0, dp - 1) == 0, $urandom_range(0, 29) == 0);
    end
    guard = 0;
    while (busy && guard < 200) begin
      cycle(0, '0, 0, 1, 0);
      guard++;
    end
    check("drain", 64'(busy), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
